// File: rtl/mdu_ctrl_pkg.sv
// Shared CPU definitions: MDU op codes, MDU FSM encoding and default
// latencies, plus the ALU and immediate-extension select constants.
package mdu_ctrl_pkg;

   // MDU operation codes (6 and 7 are reserved)
   localparam logic [2:0] MDU_MULT  = 3'd0;
   localparam logic [2:0] MDU_MULTU = 3'd1;
   localparam logic [2:0] MDU_DIV   = 3'd2;
   localparam logic [2:0] MDU_DIVU  = 3'd3;
   localparam logic [2:0] MDU_MTHI  = 3'd4;
   localparam logic [2:0] MDU_MTLO  = 3'd5;

   // Default busy latencies
   localparam int MDU_MULT_CYC_DEF = 5;
   localparam int MDU_DIV_CYC_DEF  = 10;

   // MDU sequencer states
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } mdu_state_e;

   // ALU function selects
   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_XOR = 4'd4;
   localparam logic [3:0] ALU_NOR = 4'd5;
   localparam logic [3:0] ALU_SLT = 4'd6;
   localparam logic [3:0] ALU_SLL = 4'd7;
   localparam logic [3:0] ALU_SRL = 4'd8;
   localparam logic [3:0] ALU_SRA = 4'd9;

   // Immediate extension selects
   localparam logic [1:0] EXT_ZERO = 2'd0;
   localparam logic [1:0] EXT_SIGN = 2'd1;
   localparam logic [1:0] EXT_LUI  = 2'd2;

   // Ops 0-3 (MULT/MULTU/DIV/DIVU) occupy the unit for several cycles
   function automatic logic is_multicyc(input logic [2:0] op);
      return (op[2] == 1'b0);
   endfunction

   function automatic logic is_div(input logic [2:0] op);
      return (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

endpackage

// File: rtl/mdu_ctrl_core.sv
// Combinational MDU arithmetic: 64-bit {hi,lo} result for MULT/MULTU/DIV/DIVU.
// Division by zero returns 0 here; the controller suppresses the write.
module mdu_core
   import mdu_ctrl_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [63:0] res
);

   logic signed [63:0] w_sa64;
   logic signed [63:0] w_sb64;
   logic signed [31:0] w_sq;
   logic signed [31:0] w_sr;

   assign w_sa64 = {{32{a[31]}}, a};
   assign w_sb64 = {{32{b[31]}}, b};

   // Signed divide with the zero divisor and INT_MIN/-1 overflow pinned down
   always_comb begin
      w_sq = '0;
      w_sr = '0;
      if (b == 32'd0) begin
         w_sq = '0;
         w_sr = '0;
      end else if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
         w_sq = 32'sh8000_0000;
         w_sr = '0;
      end else begin
         w_sq = $signed(a) / $signed(b);
         w_sr = $signed(a) % $signed(b);
      end
   end

   // Select the result for the requested op; hi = remainder, lo = quotient
   always_comb begin
      res = '0;
      case (op)
         MDU_MULT:  res = w_sa64 * w_sb64;
         MDU_MULTU: res = {32'd0, a} * {32'd0, b};
         MDU_DIV:   res = {w_sr, w_sq};
         MDU_DIVU:  res = (b == 32'd0) ? 64'd0 : {a % b, a / b};
         default:   res = '0;
      endcase
   end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: IDLE/RUN sequencer, latency counter, pending result
// registers and the architectural HI/LO registers.
// Handshake: start is a one-cycle request honoured only while idle; the
// pipeline must hold off (via stall_req) until busy drops, so a start seen
// while busy or with a reserved op code is dropped without any effect.
module mdu_ctrl
   import mdu_ctrl_pkg::*;
#(
   parameter int MULT_CYC = MDU_MULT_CYC_DEF,
   parameter int DIV_CYC  = MDU_DIV_CYC_DEF
)(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        md_use_d,
   output logic        busy,
   output logic        stall_req,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output mdu_state_e  dbg_state
);

   localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   mdu_state_e         r_state, w_state_nx;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nx;
   logic [31:0]        r_pend_hi, w_pend_hi_nx;
   logic [31:0]        r_pend_lo, w_pend_lo_nx;
   logic               r_pend_we, w_pend_we_nx;
   logic [31:0]        r_hi, w_hi_nx;
   logic [31:0]        r_lo, w_lo_nx;
   logic [63:0]        w_res;

   mdu_core u_core (
      .op  (op),
      .a   (a),
      .b   (b),
      .res (w_res)
   );

   // Next-state, counter, pending and HI/LO update logic
   always_comb begin
      w_state_nx   = r_state;
      w_cnt_nx     = r_cnt;
      w_pend_hi_nx = r_pend_hi;
      w_pend_lo_nx = r_pend_lo;
      w_pend_we_nx = r_pend_we;
      w_hi_nx      = r_hi;
      w_lo_nx      = r_lo;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               if (is_multicyc(op)) begin
                  w_state_nx   = ST_RUN;
                  w_cnt_nx     = is_div(op) ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
                  w_pend_hi_nx = w_res[63:32];
                  w_pend_lo_nx = w_res[31:0];
                  w_pend_we_nx = !(is_div(op) && (b == 32'd0));
               end else if (op == MDU_MTHI) begin
                  w_hi_nx = a;
               end else if (op == MDU_MTLO) begin
                  w_lo_nx = a;
               end
            end
         end
         ST_RUN: begin
            if (r_cnt == CNT_W'(1)) begin
               w_state_nx = ST_IDLE;
               w_cnt_nx   = '0;
               if (r_pend_we) begin
                  w_hi_nx = r_pend_hi;
                  w_lo_nx = r_pend_lo;
               end
            end else begin
               w_cnt_nx = r_cnt - CNT_W'(1);
            end
         end
         default: w_state_nx = ST_IDLE;
      endcase
   end

   // State and datapath registers, cleared asynchronously
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_pend_hi <= '0;
         r_pend_lo <= '0;
         r_pend_we <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
      end else begin
         r_state   <= w_state_nx;
         r_cnt     <= w_cnt_nx;
         r_pend_hi <= w_pend_hi_nx;
         r_pend_lo <= w_pend_lo_nx;
         r_pend_we <= w_pend_we_nx;
         r_hi      <= w_hi_nx;
         r_lo      <= w_lo_nx;
      end
   end

   assign busy      = (r_state == ST_RUN);
   assign stall_req = md_use_d & (busy | (start & is_multicyc(op)));
   assign hi        = r_hi;
   assign lo        = r_lo;
   assign dbg_state = r_state;

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 The block SHALL have parameter MULT_CYC, default 5, giving the busy cycles for MULT/MULTU.
REQ-002 The block SHALL have parameter DIV_CYC, default 10, giving the busy cycles for DIV/DIVU.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit; reset is asynchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit, a one-cycle request to issue an op from the E stage.
REQ-006 The block SHALL have port op, input, 3 bits, the operation code: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; values 6-7 are reserved.
REQ-007 The block SHALL have ports a and b, input, 32 bits each: a is rs/dividend/move source, b is rt/divisor.
REQ-008 The block SHALL have port md_use_d, input, 1 bit, asserted when the D-stage instruction is any MDU instruction (including MFHI/MFLO).
REQ-009 The block SHALL have port busy, output, 1 bit, high while a multicycle op is in flight.
REQ-010 The block SHALL have port stall_req, output, 1 bit, a combinational D-stage stall request.
REQ-011 The block SHALL have ports hi and lo, output, 32 bits each, the architectural HI and LO registers.

Function
REQ-012 FSM states SHALL be IDLE and RUN.
- IDLE->RUN: start with op 0-3 while idle.
- RUN->IDLE: the cycle the counter reaches 1.
REQ-013 In IDLE, start with op 0-3 SHALL latch the pending result into internal registers in the same edge, load cnt with MULT_CYC or DIV_CYC, and set busy the following cycle.
REQ-014 Results SHALL be computed as follows.
- MULT: signed 64-bit product {hi,lo}.
- MULTU: unsigned 64-bit product.
- DIV: lo = signed quotient truncated toward zero, hi = remainder with the dividend's sign.
- DIVU: unsigned quotient and remainder.
REQ-015 In RUN, cnt SHALL decrement each cycle; on the edge where cnt==1, the pending result SHALL be written to hi/lo and busy SHALL fall, so hi/lo are visible exactly N cycles after the start edge.
REQ-016 MTHI/MTLO with start while idle SHALL write a into hi or lo on that edge with no busy cycle.
REQ-017 start while busy SHALL be ignored (no state change); pipeline stall guarantees this never occurs legally, and the bench treats it as a checker error.
REQ-018 stall_req SHALL be md_use_d & (busy | (start & op<=3)).
REQ-019 DIV/DIVU with b==0 SHALL still run DIV_CYC cycles and SHALL leave hi and lo unchanged at completion.
REQ-020 DIV with a==0x80000000 and b==0xFFFFFFFF SHALL yield lo=0x80000000 and hi=0.
REQ-021 Reserved op codes with start SHALL be ignored.
REQ-022 busy SHALL never be high for more than max(MULT_CYC, DIV_CYC) consecutive cycles.

Reset
REQ-023 On reset_n low, asynchronously: state=IDLE, cnt=0, busy=0, hi=0, lo=0, and pending registers=0.
REQ-024 Reset asserted mid-RUN SHALL abort the op with no hi/lo write; the first start after release SHALL behave as from power-up.
REQ-025 stall_req SHALL be 0 during reset whenever md_use_d and start are 0.

Structure
REQ-026 Op codes (MDU_MULT..MDU_MTLO), FSM state encodings and default cycle counts SHALL live in the shared CPU definitions package, alongside the ALU/EXT select constants.
REQ-027 The arithmetic SHALL be a single sub-module mdu_core: combinational 64-bit result from op, a and b; mdu_ctrl holds only the FSM, counter, pending and HI/LO registers.
REQ-028 cnt width SHALL be clog2(max(MULT_CYC, DIV_CYC)+1).

Verification
REQ-029 MULT a=0xFFFFFFFE, b=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-030 MULTU a=0xFFFFFFFF, b=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
REQ-031 DIV a=0xFFFFFFF9 (-7), b=2 -> busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=0 -> hi/lo unchanged after 10 cycles.
REQ-032 MTHI a=0x12345678 -> hi=0x12345678 on the next edge, busy stays 0; MTLO follows likewise.
REQ-033 DIV issued with md_use_d=1 -> stall_req high in the start cycle and all 10 busy cycles, low on the cycle after busy falls.
REQ-034 reset_n pulsed low at cycle 3 of DIV -> busy=0 immediately, hi=lo=0; a following MULT 2x3 gives lo=6 after 5 cycles.
